sample_change_logger: RTL and testbench
=======================================

// Module: sample_change_logger
// PURPOSE
//   Downstream consumer of the o/p/q result stage.
//   Samples the three result bits every clock and detects any change against a stored baseline.
//   Each change becomes a timestamped record in a small FIFO, drained over a valid/ready stream.
//   Turns glitch-free combinational results into an ordered event log for the debug/readout path.
// PARAMETERS
//   TS_W   8   timestamp counter width, wraps modulo 2**TS_W
//   DEPTH  4   FIFO entries; power of two, >= 2
//   OVF_W  8   dropped-event counter width, saturating
// PORTS
//   clk        in   1               rising-edge clock
//   ret        in   1               reset, synchronous, active-high
//   en         in   1               logging enable
//   o_in       in   1               upstream result o
//   p_in       in   1               upstream result p
//   q_in       in   1               upstream result q
//   rec_valid  out  1               FIFO head holds a record
//   rec_ready  in   1               consumer accepts head this cycle
//   rec_data   out  TS_W+3          {ts[TS_W-1:0], q, p, o} of FIFO head
//   fifo_cnt   out  $clog2(DEPTH)+1 entries currently held, 0..DEPTH
//   ovf_cnt    out  OVF_W           events dropped because FIFO was full
// BEHAVIOUR
//   Reset (ret=1 at an edge):
//     - next cycle: rec_valid=0, rec_data=0, fifo_cnt=0, ovf_cnt=0, ts=0, cur_r=0, base_r=0
//     - FSM enters IDLE; FIFO contents discarded
//     - applies mid-operation with no partial records
//   Input stage: cur_r <= {q_in,p_in,o_in} every edge, regardless of en.
//   FSM, two states:
//     - IDLE: en=1 -> base_r <= cur_r, go ARMED, no record (baseline capture).
//     - ARMED: en=0 -> IDLE.
//     - ARMED: en=1 and cur_r != base_r -> event; base_r <= cur_r.
//   Timestamp:
//     - ts increments by 1 per edge while en=1 (IDLE or ARMED); holds while en=0
//     - wraps 2**TS_W-1 -> 0 with no flag
//   Event record: {ts, cur_r} as of the detecting cycle, i.e. the pre-increment ts.
//   Latency: input change captured into cur_r at edge E0
//     -> pushed at E1
//     -> rec_valid=1 after E1 if FIFO was empty (2 edges from input sampling).
//   FIFO:
//     - push = event; pop = rec_valid & rec_ready
//     - rec_data = head, stable while rec_valid=1 and rec_ready=0
//     - rec_data is 0 when empty
//     - strict first-in, first-out order; no bypass
//   Full (fifo_cnt==DEPTH):
//     - push and pop in the same cycle: both happen; count unchanged.
//     - push without pop: record dropped; ovf_cnt += 1, saturating at all-ones.
//     - base_r still updates, so a dropped change is never re-reported.
//   Empty: rec_ready is ignored; no pop and no underflow.
//   en=0 behaviour:
//     - no events are generated; ts and ovf_cnt hold
//     - the FIFO keeps draining
//     - on en rising, a fresh baseline is taken with no record
//   Simultaneous events: multiple bits changing in one cycle produce ONE record.
//   Pointer wrap: read/write pointers wrap modulo DEPTH; fifo_cnt alone disambiguates full vs empty.
// TESTING
//   T1 reset then en=1, inputs held 3'b010 for 10 cycles -> rec_valid stays 0, fifo_cnt=0, ts=10.
//   T2 armed, change 3'b010->3'b011 with ts=5 at detection, rec_ready=1
//      -> one record {8'd5,3'b011}, rec_valid pulses 1 cycle.
//   T3 rec_ready=0, 6 distinct changes, DEPTH=4
//      -> fifo_cnt=4, ovf_cnt=2; drain gives the first 4 records in order.
//   T4 full FIFO, push and pop same cycle -> fifo_cnt stays 4, ovf_cnt unchanged, new record at tail.
//   T5 ovf_cnt driven to 255 plus 3 more drops -> ovf_cnt holds 255.
//   T6 ret asserted with 3 queued records and rec_ready=0
//      -> next cycle all outputs 0; after en=1 the next change needs a new baseline first.

Source files
------------

// File: rtl/sample_change_logger.sv
// sample_change_logger: logs timestamped changes of {q,p,o} into a FIFO drained over valid/ready
// ports: clk, ret (sync active-high reset), en, o_in/p_in/q_in, rec_valid/rec_ready/rec_data, fifo_cnt, ovf_cnt
module sample_change_logger #(
  parameter int TS_W  = 8,
  parameter int DEPTH = 4,
  parameter int OVF_W = 8
) (
  input  logic                       clk,
  input  logic                       ret,
  input  logic                       en,
  input  logic                       o_in,
  input  logic                       p_in,
  input  logic                       q_in,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [TS_W+2:0]            rec_data,
  output logic [$clog2(DEPTH):0]     fifo_cnt,
  output logic [OVF_W-1:0]           ovf_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, ARMED} state_t;
  state_t          state;
  logic [2:0]      cur_r, base_r;
  logic [TS_W-1:0] ts;
  logic [TS_W+2:0] mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [CW-1:0]   cnt;
  logic            ev, pop, full, push;
  assign ev        = state == ARMED && en && cur_r != base_r;
  assign pop       = rec_valid && rec_ready;
  assign full      = cnt == CW'(DEPTH);
  assign push      = ev && (!full || pop);
  assign rec_valid = cnt != '0;
  assign rec_data  = rec_valid ? mem[rp] : '0;
  assign fifo_cnt  = cnt;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {ts, cur_r};
  always_ff @(posedge clk) begin
    if (ret) begin
      state   <= IDLE;
      cur_r   <= '0;
      base_r  <= '0;
      ts      <= '0;
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      ovf_cnt <= '0;
    end else begin
      cur_r <= {q_in, p_in, o_in};
      state <= en ? ARMED : IDLE;
      if (en) ts <= ts + 1'b1;
      // baseline follows every change, including ones dropped on a full FIFO
      if (en && (state == IDLE || cur_r != base_r)) base_r <= cur_r;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
      if (ev && !push && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sample_change_logger.sv
// tb_sample_change_logger: random + directed scoreboard bench for sample_change_logger
module tb_sample_change_logger;
  localparam int DEPTH = 4;
  logic        clk = 0;
  logic        r_ret = 1, r_en = 0, r_ready = 0;
  logic [2:0]  r_bits = 0;
  logic        rec_valid;
  logic [10:0] rec_data;
  logic [2:0]  fifo_cnt;
  logic [7:0]  ovf_cnt;
  logic [10:0] exp_q [$];
  logic [2:0]  m_cur, m_base;
  logic [7:0]  m_ts;
  logic        m_armed;
  int          m_ovf;
  bit          started = 0;
  int          n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  sample_change_logger #(.TS_W(8), .DEPTH(DEPTH), .OVF_W(8)) dut (
    .clk(clk), .ret(r_ret), .en(r_en), .o_in(r_bits[0]), .p_in(r_bits[1]), .q_in(r_bits[2]),
    .rec_valid(rec_valid), .rec_ready(r_ready), .rec_data(rec_data),
    .fifo_cnt(fifo_cnt), .ovf_cnt(ovf_cnt)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask
  task automatic model_edge();
    if (r_ret) begin
      exp_q.delete();
      m_cur = 0; m_base = 0; m_ts = 0; m_armed = 0; m_ovf = 0;
      started = 1;
    end else begin
      if (r_en && m_armed && m_cur != m_base) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({m_ts, m_cur});
        else if (m_ovf < 255) m_ovf++;
      end
      if (r_en) begin
        m_base = m_cur;
        m_ts = m_ts + 8'd1;
      end
      m_armed = r_en;
      m_cur = r_bits;
    end
  endtask
  task automatic step(input logic rt, input logic e, input logic [2:0] b, input logic rd);
    r_ret = rt; r_en = e; r_bits = b; r_ready = rd;
    @(posedge clk);
    model_edge();
    #1;
  endtask
  always @(negedge clk) if (started) begin
    chk("fifo_cnt", fifo_cnt, exp_q.size());
    chk("ovf_cnt", ovf_cnt, m_ovf);
    chk("rec_valid", rec_valid, exp_q.size() != 0);
    chk("rec_data", rec_data, exp_q.size() != 0 ? exp_q[0] : 11'd0);
    if (exp_q.size() != 0 && r_ready && !r_ret) void'(exp_q.pop_front());
  end
  initial begin
    logic [2:0] b;
    repeat (2) step(1, 0, 3'b000, 0);
    repeat (10) step(0, 1, 3'b010, 1);
    repeat (4) step(0, 1, 3'b011, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 3'(i), 0);
    repeat (2) step(0, 1, 3'b101, 0);
    step(0, 1, 3'b110, 0);
    step(0, 1, 3'b110, 1);
    repeat (8) step(0, 1, 3'b110, 1);
    b = 3'b000;
    for (int i = 0; i < 270; i++) begin
      b = ~b;
      step(0, 1, b, 0);
    end
    repeat (6) step(0, 1, b, 1);
    repeat (3) step(0, 0, b, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 3'(i + 1), 0);
    step(1, 1, 3'b111, 0);
    step(0, 1, 3'b111, 1);
    step(0, 1, 3'b001, 1);
    repeat (3) step(0, 1, 3'b001, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) b = 3'($urandom);
      step($urandom_range(0, 599) == 0, $urandom_range(0, 9) != 0, b, $urandom_range(0, 2) != 0);
    end
    repeat (8) step(0, 0, b, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
